// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: request sequencer states and data op
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } req_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

endpackage

// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - signal bundle between datapath, decoder and memory controller
interface request_unit_if #(
  parameter int WORD_W = 32
) (
  input logic clk
);
  logic              n_rst;
  logic [WORD_W-1:0] imemload;
  logic              ihit;
  logic              dhit;
  logic              MemRd;
  logic              MemWr;
  logic              HALT;
  logic [WORD_W-1:0] instr;
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic              PCEn;
  logic              halt;
  logic              err;

  modport ru (
    input  clk, n_rst, imemload, ihit, dhit, MemRd, MemWr, HALT,
    output instr, iREN, dREN, dWEN, PCEn, halt, err
  );

  modport mem (
    input  iREN, dREN, dWEN,
    output imemload, ihit, dhit
  );

  modport dp (
    input  instr, PCEn, halt, err,
    output MemRd, MemWr, HALT
  );
endinterface

// File: rtl/request_watchdog.sv
// rtl/request_watchdog.sv - wait-cycle counter; flags the cycle that would reach MAX_WAIT
module request_watchdog #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Only a wait cycle can expire, so a hit on the limit cycle wins.
  assign expire = inc && (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - fetch/exec/data sequencer in front of the decoder; watchdog under REQUEST_WATCHDOG_EN
module request_unit #(
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [WORD_W-1:0] imemload,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic              HALT,
  output logic [WORD_W-1:0] instr,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              PCEn,
  output logic              halt,
  output logic              err
);
  import cpu_types_pkg::*;

  req_state_e        state_q, state_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  mem_op_e           op_q, op_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic              pcen;
  logic              waiting;
  logic              wd_expire;

  assign waiting = ((state_q == FETCH) && !ihit) || ((state_q == DATA) && !dhit);

`ifdef REQUEST_WATCHDOG_EN
  request_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (n_rst),
    .clear  (state_d != state_q),
    .inc    (waiting),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_d    = op_q;
    req_d   = req_q;
    err_d   = err_q;
    pcen    = 1'b0;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          instr_d = imemload;
          state_d = EXEC;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = HALTED;
        end
      end
      EXEC: begin
        if (HALT) begin
          state_d = HALTED;
        end else if (MemWr || MemRd) begin
          op_d    = MemWr ? OP_WR : OP_RD;
          req_d   = 1'b1;
          state_d = DATA;
        end else begin
          pcen    = 1'b1;
          state_d = FETCH;
        end
      end
      DATA: begin
        if (dhit) begin
          pcen    = 1'b1;
          req_d   = 1'b0;
          state_d = FETCH;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = HALTED;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= FETCH;
      instr_q <= '0;
      op_q    <= OP_RD;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_q    <= op_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign instr = instr_q;
  assign iREN  = (state_q == FETCH);
  assign dREN  = req_q && (op_q == OP_RD);
  assign dWEN  = req_q && (op_q == OP_WR);
  assign PCEn  = pcen;
  assign halt  = (state_q == HALTED);
  assign err   = err_q;
endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed bench for request_unit
module tb_request_unit;
  localparam int WORD_W = 32;
`ifdef REQUEST_WATCHDOG_EN
  localparam int LOAD_WAIT = 3;
`else
  localparam int LOAD_WAIT = 4;
`endif
  localparam logic [31:0] I_ADD = 32'h0022_1820;
  localparam logic [31:0] I_LW  = 32'h8C22_0004;
  localparam logic [31:0] I_SW  = 32'hAC22_0008;
  localparam logic [31:0] I_HLT = 32'hFC00_0000;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [WORD_W-1:0] imemload;
  logic              ihit, dhit, MemRd, MemWr, HALT;
  logic [WORD_W-1:0] instr;
  logic              iREN, dREN, dWEN, PCEn, halt, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  request_unit #(
    .WORD_W   (WORD_W),
    .MAX_WAIT (4)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .imemload (imemload),
    .ihit     (ihit),
    .dhit     (dhit),
    .MemRd    (MemRd),
    .MemWr    (MemWr),
    .HALT     (HALT),
    .instr    (instr),
    .iREN     (iREN),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .PCEn     (PCEn),
    .halt     (halt),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b1; imemload = '0; ihit = 1'b0; dhit = 1'b0;
    MemRd = 1'b0; MemWr = 1'b0; HALT = 1'b0;
    cyc();
    check("rst_iren", iREN, 1);
    check("rst_dren", dREN, 0);
    check("rst_dwen", dWEN, 0);
    check("rst_pcen", PCEn, 0);
    check("rst_halt", halt, 0);
    check("rst_err", err, 0);
    check("rst_instr", instr, 0);

    // Non-memory instruction: fetch then commit in EXEC.
    n_rst = 1'b0; ihit = 1'b1; imemload = I_ADD;
    cyc();
    ihit = 1'b0;
    check("add_instr", instr, I_ADD);
    check("add_iren_exec", iREN, 0);
    check("add_pcen", PCEn, 1);
    cyc();
    check("add_back_fetch", iREN, 1);
    check("add_pcen_low", PCEn, 0);

    // Load with a stretched data phase.
    ihit = 1'b1; imemload = I_LW;
    cyc();
    ihit = 1'b0; MemRd = 1'b1;
    #1;
    check("lw_exec_pcen", PCEn, 0);
    check("lw_exec_dren", dREN, 0);
    cyc();
    MemRd = 1'b0;
    for (int i = 0; i < LOAD_WAIT; i++) begin
      check("lw_wait_dren", dREN, 1);
      check("lw_wait_dwen", dWEN, 0);
      check("lw_wait_pcen", PCEn, 0);
      cyc();
    end
    dhit = 1'b1;
    #1;
    check("lw_hit_pcen", PCEn, 1);
    check("lw_hit_dren", dREN, 1);
    cyc();
    dhit = 1'b0;
    check("lw_done_dren", dREN, 0);
    check("lw_done_pcen", PCEn, 0);
    check("lw_done_iren", iREN, 1);

    // MemRd and MemWr together: write wins.
    ihit = 1'b1; imemload = I_SW;
    cyc();
    ihit = 1'b0; MemRd = 1'b1; MemWr = 1'b1;
    cyc();
    MemRd = 1'b0; MemWr = 1'b0;
    check("rw_dwen", dWEN, 1);
    check("rw_dren", dREN, 0);
    cyc();
    check("rw_dwen_hold", dWEN, 1);
    dhit = 1'b1;
    #1;
    check("rw_hit_pcen", PCEn, 1);
    cyc();
    dhit = 1'b0;
    check("rw_done_dwen", dWEN, 0);
    check("rw_done_iren", iREN, 1);

    // Halt, then stray handshakes are ignored until reset.
    ihit = 1'b1; imemload = I_HLT;
    cyc();
    ihit = 1'b0; HALT = 1'b1;
    #1;
    check("hlt_exec_pcen", PCEn, 0);
    cyc();
    HALT = 1'b0;
    check("hlt_halt", halt, 1);
    check("hlt_iren", iREN, 0);
    ihit = 1'b1; dhit = 1'b1; imemload = 32'h1234_5678;
    #1;
    check("hlt_stray_pcen", PCEn, 0);
    cyc();
    ihit = 1'b0; dhit = 1'b0;
    check("hlt_instr_kept", instr, I_HLT);
    check("hlt_sticky", halt, 1);
    check("hlt_dren", dREN, 0);
    n_rst = 1'b1;
    #1;
    check("hlt_rst_halt", halt, 0);
    check("hlt_rst_iren", iREN, 1);
    check("hlt_rst_instr", instr, 0);
    cyc();
    n_rst = 1'b0;

    // Asynchronous reset in the middle of a store.
    ihit = 1'b1; imemload = I_SW;
    cyc();
    ihit = 1'b0; MemWr = 1'b1;
    cyc();
    MemWr = 1'b0;
    check("arst_dwen_before", dWEN, 1);
    #2 n_rst = 1'b1;
    #1;
    check("arst_dwen_drop", dWEN, 0);
    check("arst_iren", iREN, 1);
    cyc();
    n_rst = 1'b0;
    cyc();
    check("arst_fetch", iREN, 1);
    dhit = 1'b1;
    #1;
    check("stray_dhit_pcen", PCEn, 0);
    cyc();
    dhit = 1'b0;
    check("stray_dhit_dren", dREN, 0);
    check("stray_dhit_iren", iREN, 1);

    // Long fetch wait: timeout with the watchdog, unbounded without.
    n_rst = 1'b1;
    cyc();
    n_rst = 1'b0;
`ifdef REQUEST_WATCHDOG_EN
    repeat (3) cyc();
    check("wd_err_early", err, 0);
    check("wd_halt_early", halt, 0);
    cyc();
    check("wd_err", err, 1);
    check("wd_halt", halt, 1);
    check("wd_iren", iREN, 0);
    n_rst = 1'b1;
    cyc();
    n_rst = 1'b0;
    repeat (3) cyc();
    ihit = 1'b1; imemload = I_ADD;
    cyc();
    ihit = 1'b0;
    check("wd_hit_err", err, 0);
    check("wd_hit_halt", halt, 0);
    check("wd_hit_exec", instr, I_ADD);
`else
    repeat (10) cyc();
    check("nowd_err", err, 0);
    check("nowd_halt", halt, 0);
    check("nowd_iren", iREN, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
